// File: rtl/bird_pkg.sv
// bird_pkg: shared types and constants for the bird sprite motion logic.
//   bird_state_t : motion state encoding (IDLE=0, FLY=1, FALL=2, OVER=3)
//   KEY_FLAP     : keycode that triggers a flap (space bar)
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    FALL = 2'd2,
    OVER = 2'd3
  } bird_state_t;

  localparam logic [15:0] KEY_FLAP = 16'h2C;

endpackage

// File: rtl/bird_motion_key_edge_detect.sv
// key_edge_detect: one-frame pulse on the first frame a given keycode appears.
// Holding the key yields a single pulse; any other keycode is ignored.
//   frame_clk : frame-rate clock
//   Reset     : asynchronous, active-high reset
//   keyboard  : current keycode
//   pulse     : high for one frame when keyboard first equals KEYCODE
module key_edge_detect #(
  parameter int               KEY_W   = 16,
  parameter logic [KEY_W-1:0] KEYCODE = KEY_W'('h2C)
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [KEY_W-1:0] keyboard,
  output logic             pulse
);

  logic match;
  logic prev;

  assign match = (keyboard == KEYCODE);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) prev <= 1'b0;
    else       prev <= match;
  end

  assign pulse = match & ~prev;

endmodule

// File: rtl/bird_motion.sv
// bird_motion: vertical trajectory of the player sprite, advanced once per
// video frame. Signed velocity with per-frame gravity, edge-triggered flap
// impulse and an IDLE/FLY/FALL/OVER state machine.
//   frame_clk : frame-rate clock, all state advances on its rising edge
//   Reset     : asynchronous, active-high reset
//   keyboard  : current keycode; KEY_FLAP (space) = flap
//   hit       : pipe collision flag (level)
//   BirdX     : sprite centre X (constant X_CENTER)
//   BirdY     : sprite centre Y
//   BirdS     : sprite half-size (constant SIZE)
//   BirdVel   : current signed velocity
//   state     : current motion state
//   game_over : high while in OVER
// Optional feature macro: BIRD_FLAP_COOLDOWN_EN adds a flap cooldown in FLY.
//
// state | meaning
// IDLE  | waiting at start position, first flap launches
// FLY   | under player control, gravity plus flaps
// FALL  | pipe hit, flaps ignored, dropping to the ground
// OVER  | on the ground, next flap restarts to IDLE
module bird_motion
  import bird_pkg::*;
#(
  parameter int POS_W    = 10,
  parameter int VEL_W    = 6,
  parameter int X_CENTER = 160,
  parameter int Y_CENTER = 240,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int SIZE     = 4,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -6,
  parameter int VEL_MAX  = 7,
  parameter int COOLDOWN = 4
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [15:0]             keyboard,
  input  logic                    hit,
  output logic [POS_W-1:0]        BirdX,
  output logic [POS_W-1:0]        BirdY,
  output logic [POS_W-1:0]        BirdS,
  output logic signed [VEL_W-1:0] BirdVel,
  output logic [1:0]              state,
  output logic                    game_over
);

  // Two extra bits so Y +/- velocity +/- SIZE never wraps before comparison.
  localparam int AW = POS_W + 2;

  localparam logic signed [AW-1:0]    GRAV_A   = AW'(GRAVITY);
  localparam logic signed [AW-1:0]    VMAX_A   = AW'(VEL_MAX);
  localparam logic signed [AW-1:0]    FLAP_A   = AW'(FLAP_VEL);
  localparam logic signed [AW-1:0]    SIZE_A   = AW'(SIZE);
  localparam logic signed [AW-1:0]    YMIN_A   = AW'(Y_MIN);
  localparam logic signed [AW-1:0]    YMAX_A   = AW'(Y_MAX);
  localparam logic [POS_W-1:0]        Y_START  = POS_W'(Y_CENTER);
  localparam logic [POS_W-1:0]        Y_LAUNCH = POS_W'(Y_CENTER + FLAP_VEL);
  localparam logic [POS_W-1:0]        Y_TOP    = POS_W'(Y_MIN + SIZE);
  localparam logic [POS_W-1:0]        Y_BOT    = POS_W'(Y_MAX - SIZE);
  localparam logic signed [VEL_W-1:0] FLAP_V   = VEL_W'(FLAP_VEL);

  if (VEL_MAX >= (1 << (VEL_W - 1))) begin : g_bad_vel_max
    $error("bird_motion: VEL_MAX does not fit the signed velocity register");
  end
  if (FLAP_VEL < -(1 << (VEL_W - 1))) begin : g_bad_flap_vel
    $error("bird_motion: FLAP_VEL does not fit the signed velocity register");
  end
  if (COOLDOWN < 0) begin : g_bad_cooldown
    $error("bird_motion: COOLDOWN must be non-negative");
  end

  bird_state_t             state_q, state_d;
  logic [POS_W-1:0]        y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;

  logic                    flap_pulse;
  logic                    flap_ok;
  logic signed [AW-1:0]    vel_ext, vel_sum, vel_grav, vel_try, y_try;
  logic                    top_hit, bot_hit;

  key_edge_detect #(
    .KEY_W   (16),
    .KEYCODE (KEY_FLAP)
  ) u_flap_edge (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keyboard  (keyboard),
    .pulse     (flap_pulse)
  );

`ifdef BIRD_FLAP_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  logic [CD_W-1:0] cd_q;
  logic            load_cd;

  assign flap_ok = flap_pulse && (cd_q == '0);
  // The launch from IDLE counts as an accepted flap and arms the cooldown.
  assign load_cd = flap_pulse &&
                   ((state_q == IDLE) || ((state_q == FLY) && flap_ok && !hit));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)                cd_q <= '0;
    else if (state_d == IDLE) cd_q <= '0;
    else if (load_cd)         cd_q <= CD_W'(COOLDOWN);
    else if (cd_q != '0)      cd_q <= cd_q - 1'b1;
  end
`else
  assign flap_ok = flap_pulse;
`endif

  // Candidate velocity/position for this frame. A hit overrides the flap, so
  // the bottom check on a hit edge uses the gravity-only velocity.
  always_comb begin
    vel_ext  = AW'(vel_q);
    vel_sum  = vel_ext + GRAV_A;
    vel_grav = (vel_sum > VMAX_A) ? VMAX_A : vel_sum;
    vel_try  = ((state_q == FLY) && flap_ok && !hit) ? FLAP_A : vel_grav;
    y_try    = $signed({2'b00, y_q}) + vel_try;
    top_hit  = (y_try - SIZE_A) < YMIN_A;
    bot_hit  = (y_try + SIZE_A) >= YMAX_A;
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    case (state_q)
      IDLE: begin
        y_d   = Y_START;
        vel_d = '0;
        if (flap_pulse) begin
          state_d = FLY;
          vel_d   = FLAP_V;
          y_d     = Y_LAUNCH;
        end
      end
      FLY: begin
        if (bot_hit) begin
          state_d = OVER;
          y_d     = Y_BOT;
          vel_d   = '0;
        end else if (hit) begin
          state_d = FALL;
          vel_d   = '0;
        end else if (top_hit) begin
          y_d   = Y_TOP;
          vel_d = '0;
        end else begin
          y_d   = y_try[POS_W-1:0];
          vel_d = vel_try[VEL_W-1:0];
        end
      end
      FALL: begin
        if (bot_hit) begin
          state_d = OVER;
          y_d     = Y_BOT;
          vel_d   = '0;
        end else begin
          y_d   = y_try[POS_W-1:0];
          vel_d = vel_try[VEL_W-1:0];
        end
      end
      OVER: begin
        if (flap_pulse) begin
          state_d = IDLE;
          y_d     = Y_START;
          vel_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = Y_START;
        vel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      y_q     <= Y_START;
      vel_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
    end
  end

  assign BirdX     = POS_W'(X_CENTER);
  assign BirdS     = POS_W'(SIZE);
  assign BirdY     = y_q;
  assign BirdVel   = vel_q;
  assign state     = state_q;
  assign game_over = (state_q == OVER);

endmodule
